serial_subtractor: RTL and testbench
====================================

// Module: serial_subtractor
// PURPOSE
//  Bit-serial ripple subtractor: computes diff = a - b - bin, one bit per clock, LSB first.
//  Companion to the combinational ripple-carry adder.
//  Trades latency for a single 1-bit full-subtractor cell.
//  Sits behind a start/done handshake so a controller can issue operands and collect results.
// PARAMETERS
//  WIDTH   8   operand/result width in bits (>=2)
// PORTS
//  clk    in   1      rising-edge clock; only clock in the block
//  rst    in   1      synchronous, active-high reset
//  start  in   1      request; sampled only in IDLE
//  a      in   WIDTH  minuend, captured on accepted start
//  b      in   WIDTH  subtrahend, captured on accepted start
//  bin    in   1      borrow-in, captured on accepted start
//  busy   out  1      high in RUN and DONE
//  done   out  1      one-cycle pulse: diff/bout valid
//  diff   out  WIDTH  a - b - bin mod 2^WIDTH; held until next accepted start
//  bout   out  1      borrow-out: 1 iff a < b + bin (unsigned); held with diff
// BEHAVIOUR
//  - Reset (rst=1 at clock edge): state=IDLE, busy=0, done=0, diff=0, bout=0, bit counter=0.
//    Reset wins over every other input and aborts any operation in progress; no done is issued.
//  - IDLE: start=1 at edge k -> latch a,b into shift regs, borrow reg<=bin, cnt<=0, state<=RUN.
//    diff/bout keep their previous values until the last bit completes.
//  - RUN: one bit per edge, i = cnt (0..WIDTH-1):
//    d_i = a_i ^ b_i ^ br
//    br' = (~a_i & b_i) | (~(a_i ^ b_i) & br)
//    d_i is shifted into the result reg from MSB side, a/b regs shift right, cnt++.
//    At cnt==WIDTH-1: state<=DONE; diff<=final result; bout<=br'.
//  - DONE: done=1 for exactly one cycle, busy=1; next edge -> IDLE.
//  - Latency: start accepted at edge k -> done high during cycle after edge k+WIDTH.
//    Back-to-back throughput: one op per WIDTH+2 cycles.
//  - start while busy (RUN or DONE): ignored, no effect on operands or result.
//    start held high continuously: re-accepted on first IDLE cycle.
//  - Operand inputs changing during RUN: no effect (captured copies used).
//  - Boundaries:
//    a=b, bin=0 -> diff=0, bout=0.
//    a=0, b=0, bin=1 -> diff=all-ones, bout=1.
//    a=all-ones, b=0 -> diff=a, bout=0.
//  - All outputs registered; no combinational path from inputs to outputs.
// STRUCTURE
//  - Package sub_pkg: state encoding localparams S_IDLE=2'd0, S_RUN=2'd1, S_DONE=2'd2.
//    Also a counter-width function clog2(WIDTH) for cnt sizing.
//  - Sub-module full_subtractor (a, b, bin -> d, bout): purely combinational 1-bit cell,
//    instantiated once.
//  - Top holds the FSM, bit counter, operand shift regs, borrow flop and result reg.
// TESTING
//  - rst for 2 cycles -> busy=0, done=0, diff=0, bout=0.
//  - a=20,b=10,bin=0,start -> done after WIDTH+1 cycles, diff=10, bout=0.
//  - a=100,b=200,bin=1 -> diff=155, bout=1.
//  - a=220,b=150,bin=0 -> diff=70, bout=0.
//  - a=50,b=100,bin=0 -> diff=206, bout=1.
//  - a=0,b=0,bin=1 -> diff=255, bout=1.
//  - start a=50,b=100; change a/b and pulse start mid-RUN -> result still 206/1, single done.
//  - Assert rst at cnt=3 of an op -> no done, outputs 0.
//    New op 20-10 afterwards -> diff=10.
//  - Random sweep (1000 ops, WIDTH=8 and WIDTH=16) vs reference model {bout,diff} = a-b-bin;
//    check done width = 1 cycle, latency = WIDTH+1.

Source files
------------

// File: rtl/sub_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM state encodings and
// a ceiling-log2 helper used to size the bit counter.
package sub_pkg;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    // Never returns less than 1, so a counter sized from it is at least one bit wide.
    function automatic int clog2(input int n);
        int r;
        r = 1;
        for (int unsigned i = 1; i < 31; i++) begin
            if ((1 << i) < n) r = int'(i) + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/full_subtractor.sv
// One-bit full-subtractor cell: d = a - b - bin, bout set when a borrow
// propagates to the next bit.
module full_subtractor (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bout
);

    always_comb begin
        d    = a ^ b ^ bin;
        bout = (~a & b) | (~(a ^ b) & bin);
    end

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor behind a start/done handshake: computes
// diff = a - b - bin LSB first, using one full-subtractor cell.
module serial_subtractor
    import sub_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout
);

    localparam int CW = clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    logic [1:0]       state;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] areg;
    logic [WIDTH-1:0] breg;
    logic [WIDTH-2:0] res;
    logic             br;

    logic             d_bit;
    logic             br_next;
    logic [WIDTH-1:0] res_next;

    full_subtractor u_cell (
        .a    (areg[0]),
        .b    (breg[0]),
        .bin  (br),
        .d    (d_bit),
        .bout (br_next)
    );

    // res keeps only the upper WIDTH-1 bits; the final shift lands straight in diff.
    assign res_next = {d_bit, res};

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
            diff  <= '0;
            bout  <= 1'b0;
            cnt   <= '0;
            areg  <= '0;
            breg  <= '0;
            res   <= '0;
            br    <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        areg  <= a;
                        breg  <= b;
                        br    <= bin;
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= S_RUN;
                    end
                end
                S_RUN: begin
                    areg <= {1'b0, areg[WIDTH-1:1]};
                    breg <= {1'b0, breg[WIDTH-1:1]};
                    res  <= res_next[WIDTH-1:1];
                    br   <= br_next;
                    cnt  <= cnt + 1'b1;
                    if (cnt == LAST) begin
                        diff  <= res_next;
                        bout  <= br_next;
                        done  <= 1'b1;
                        state <= S_DONE;
                    end
                end
                S_DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor: directed vector table, handshake
// corner sequences and a random sweep at WIDTH=8 and WIDTH=16.
module tb_serial_subtractor;

    logic        clk = 1'b0;
    logic        rst;

    logic        start8, bin8, busy8, done8, bout8;
    logic [7:0]  a8, b8, diff8;
    logic        start16, bin16, busy16, done16, bout16;
    logic [15:0] a16, b16, diff16;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    serial_subtractor #(.WIDTH(8)) u_dut8 (
        .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8), .bin(bin8),
        .busy(busy8), .done(done8), .diff(diff8), .bout(bout8)
    );

    serial_subtractor #(.WIDTH(16)) u_dut16 (
        .clk(clk), .rst(rst), .start(start16), .a(a16), .b(b16), .bin(bin16),
        .busy(busy16), .done(done16), .diff(diff16), .bout(bout16)
    );

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       bin;
        logic [7:0] diff;
        logic       bout;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic logic cur_done(input bit w16);
        return w16 ? done16 : done8;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // lat = edges from the accepting edge to the first cycle with done high
    task automatic run_op(input bit w16, input logic [15:0] av, input logic [15:0] bv,
                          input logic bi, output logic [15:0] dv, output logic bo,
                          output int lat, output int dwid);
        tick();
        if (w16) begin a16 = av; b16 = bv; bin16 = bi; start16 = 1'b1; end
        else     begin a8 = av[7:0]; b8 = bv[7:0]; bin8 = bi; start8 = 1'b1; end
        tick();
        start8 = 1'b0;
        start16 = 1'b0;
        lat = 0;
        do begin
            tick();
            lat++;
        end while (!cur_done(w16) && lat < 64);
        dv = w16 ? diff16 : {8'h00, diff8};
        bo = w16 ? bout16 : bout8;
        dwid = 0;
        while (cur_done(w16) && dwid < 8) begin
            dwid++;
            tick();
        end
    endtask

    initial begin
        vec_t        vecs[10];
        logic [15:0] dv;
        logic        bo;
        int          lat, dwid, ndone, t1, t2;
        logic [8:0]  r9;
        logic [16:0] r17;
        logic [15:0] ra, rb;
        logic        rbi;

        vecs[0] = '{8'd20,  8'd10,  1'b0, 8'd10,  1'b0};
        vecs[1] = '{8'd100, 8'd200, 1'b1, 8'd155, 1'b1};
        vecs[2] = '{8'd220, 8'd150, 1'b0, 8'd70,  1'b0};
        vecs[3] = '{8'd50,  8'd100, 1'b0, 8'd206, 1'b1};
        vecs[4] = '{8'd0,   8'd0,   1'b1, 8'd255, 1'b1};
        vecs[5] = '{8'd77,  8'd77,  1'b0, 8'd0,   1'b0};
        vecs[6] = '{8'd255, 8'd0,   1'b0, 8'd255, 1'b0};
        vecs[7] = '{8'd255, 8'd255, 1'b1, 8'd255, 1'b1};
        vecs[8] = '{8'd0,   8'd255, 1'b0, 8'd1,   1'b1};
        vecs[9] = '{8'd128, 8'd127, 1'b1, 8'd0,   1'b0};

        rst = 1'b1;
        start8 = 1'b0; a8 = '0; b8 = '0; bin8 = 1'b0;
        start16 = 1'b0; a16 = '0; b16 = '0; bin16 = 1'b0;
        repeat (2) tick();
        rst = 1'b0;
        check("reset busy8", 32'(busy8), 0);
        check("reset done8", 32'(done8), 0);
        check("reset diff8", 32'(diff8), 0);
        check("reset bout8", 32'(bout8), 0);
        check("reset busy16", 32'(busy16), 0);
        check("reset diff16", 32'(diff16), 0);

        foreach (vecs[i]) begin
            run_op(1'b0, {8'h00, vecs[i].a}, {8'h00, vecs[i].b}, vecs[i].bin, dv, bo, lat, dwid);
            check($sformatf("vec%0d diff", i), 32'(dv), 32'(vecs[i].diff));
            check($sformatf("vec%0d bout", i), 32'(bo), 32'(vecs[i].bout));
            check($sformatf("vec%0d latency", i), 32'(lat), 8);
            check($sformatf("vec%0d done width", i), 32'(dwid), 1);
        end

        // Operand change and stray start during RUN must be ignored
        tick();
        a8 = 8'd50; b8 = 8'd100; bin8 = 1'b0; start8 = 1'b1;
        tick();
        start8 = 1'b0;
        repeat (2) tick();
        a8 = 8'd7; b8 = 8'd3; bin8 = 1'b1; start8 = 1'b1;
        tick();
        start8 = 1'b0;
        check("midrun busy", 32'(busy8), 1);
        ndone = 0;
        dv = '0;
        bo = 1'b0;
        for (int i = 0; i < 30; i++) begin
            if (done8) begin
                ndone++;
                dv = {8'h00, diff8};
                bo = bout8;
            end
            tick();
        end
        check("midrun done count", 32'(ndone), 1);
        check("midrun diff", 32'(dv), 206);
        check("midrun bout", 32'(bo), 1);
        check("midrun diff held", 32'(diff8), 206);

        // Start held high: re-accepted on the first IDLE cycle
        tick();
        a8 = 8'd200; b8 = 8'd1; bin8 = 1'b0; start8 = 1'b1;
        t1 = -1;
        t2 = -1;
        for (int e = 1; e <= 40; e++) begin
            tick();
            if (done8) begin
                if (t1 < 0) t1 = e;
                else if (t2 < 0) t2 = e;
            end
        end
        start8 = 1'b0;
        check("held first done", 32'(t1), 9);
        check("held spacing", 32'(t2 - t1), 10);
        check("held diff", 32'(diff8), 199);
        lat = 0;
        while (busy8 && lat < 30) begin
            tick();
            lat++;
        end
        check("held drains to idle", 32'(busy8), 0);

        // Reset mid-operation aborts without a done pulse
        tick();
        a8 = 8'd20; b8 = 8'd10; bin8 = 1'b0; start8 = 1'b1;
        tick();
        start8 = 1'b0;
        repeat (3) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("abort busy", 32'(busy8), 0);
        check("abort done", 32'(done8), 0);
        check("abort diff", 32'(diff8), 0);
        check("abort bout", 32'(bout8), 0);
        ndone = 0;
        for (int i = 0; i < 20; i++) begin
            if (done8) ndone++;
            tick();
        end
        check("abort no done", 32'(ndone), 0);
        run_op(1'b0, 16'd20, 16'd10, 1'b0, dv, bo, lat, dwid);
        check("after abort diff", 32'(dv), 10);
        check("after abort bout", 32'(bo), 0);

        for (int n = 0; n < 1000; n++) begin
            ra = 16'($urandom_range(0, 255));
            rb = 16'($urandom_range(0, 255));
            rbi = 1'($urandom_range(0, 1));
            r9 = {1'b0, ra[7:0]} - {1'b0, rb[7:0]} - 9'(rbi);
            run_op(1'b0, ra, rb, rbi, dv, bo, lat, dwid);
            check("rand8 result", {15'h0, bo, dv}, {15'h0, r9[8], 8'h00, r9[7:0]});
            check("rand8 latency", 32'(lat), 8);
            check("rand8 done width", 32'(dwid), 1);
        end

        for (int n = 0; n < 1000; n++) begin
            ra = 16'($urandom);
            rb = 16'($urandom);
            rbi = 1'($urandom_range(0, 1));
            r17 = {1'b0, ra} - {1'b0, rb} - 17'(rbi);
            run_op(1'b1, ra, rb, rbi, dv, bo, lat, dwid);
            check("rand16 result", {15'h0, bo, dv}, {15'h0, r17});
            check("rand16 latency", 32'(lat), 16);
            check("rand16 done width", 32'(dwid), 1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
